timer_fnd_led_display: RTL

Display back-end for the 10 Hz timer counter. It takes the 32-bit `counter` value, clamps it to 655,359,999 and splits it as quotient × 10000 + remainder. The 16-bit quotient drives the LEDs. The 4-digit decimal remainder drives a multiplexed common-anode 7-segment FND. Conversion is a multi-cycle divide plus double-dabble FSM, and digit scanning is prescaler-driven.

---
 rtl/timer_fnd_led_display.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/timer_fnd_led_display.sv
// timer_fnd_led_display: clamps the timer count, splits it into LED quotient and 4-digit FND remainder.
// Optional build macro FND_LEADING_BLANK_EN blanks leading zero digits 3 and 2.
`default_nettype none

module timer_fnd_led_display #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1000,
  parameter int unsigned MAX_NUM = 655_359_999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] counter,
  output logic [15:0] led,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data,
  output logic        busy
);

  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, DIV, BCD, DONE} state_t;

  state_t            state, next_state;
  logic [31:0]       work;
  logic [14:0]       rem;
  logic [15:0]       bcd;
  logic [13:0]       bin;
  logic [4:0]        iter;
  logic [31:0]       last_cap;
  logic              force_conv;
  logic [3:0][3:0]   dig;
  logic [PW-1:0]     presc;
  logic [1:0]        idx;

  logic [31:0]       clamped;
  logic [14:0]       rem_shift;
  logic              div_ge;
  logic [14:0]       rem_next;
  logic [15:0]       bcd_adj;
  logic              presc_tc;
  logic [1:0]        next_idx;
  logic [3:0]        seg_dig;
  logic [7:0]        seg_code;

  assign clamped   = (counter > MAX_NUM) ? MAX_NUM : counter;
  assign rem_shift = {rem[13:0], work[31]};
  assign div_ge    = (rem_shift >= 15'd10000);
  assign rem_next  = div_ge ? (rem_shift - 15'd10000) : rem_shift;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (force_conv || (counter != last_cap)) next_state = LOAD;
      LOAD: next_state = DIV;
      DIV:  if (iter == 5'd31) next_state = BCD;
      BCD:  if (iter == 5'd13) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work       <= '0;
      rem        <= '0;
      bcd        <= '0;
      bin        <= '0;
      iter       <= '0;
      last_cap   <= '0;
      force_conv <= 1'b1;
      busy       <= 1'b0;
      led        <= '0;
      dig        <= '0;
    end else begin
      case (state)
        IDLE: iter <= '0;
        LOAD: begin
          work       <= clamped;
          rem        <= '0;
          last_cap   <= counter;
          force_conv <= 1'b0;
          busy       <= 1'b1;
          iter       <= '0;
        end
        DIV: begin
          // Dividend shifts out of work while quotient bits shift in behind it.
          work <= {work[30:0], div_ge};
          rem  <= rem_next;
          if (iter == 5'd31) begin
            iter <= '0;
            bin  <= rem_next[13:0];
            bcd  <= '0;
          end else begin
            iter <= iter + 5'd1;
          end
        end
        BCD: begin
          bcd  <= {bcd_adj[14:0], bin[13]};
          bin  <= {bin[12:0], 1'b0};
          iter <= iter + 5'd1;
        end
        DONE: begin
          led  <= work[15:0];
          dig  <= bcd;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign presc_tc = (presc == PW'(SCAN_DIV - 1));
  assign next_idx = presc_tc ? (idx + 2'd1) : idx;
  assign seg_dig  = dig[next_idx];

  // Decode targets the digit that will be selected after this edge, so com and data move together.
  always_comb begin
    case (seg_dig)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
    if (next_idx == 2'd1 && seg_dig <= 4'd9) seg_code[7] = 1'b0;
`ifdef FND_LEADING_BLANK_EN
    if (next_idx == 2'd3 && led == 16'd0 && dig[3] == 4'd0) seg_code = 8'hFF;
    if (next_idx == 2'd2 && led == 16'd0 && dig[3] == 4'd0 && dig[2] == 4'd0) seg_code = 8'hFF;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      idx      <= '0;
      fnd_com  <= 4'b1110;
      fnd_data <= 8'hC0;
    end else begin
      presc    <= presc_tc ? '0 : presc + PW'(1);
      idx      <= next_idx;
      fnd_com  <= ~(4'b0001 << next_idx);
      fnd_data <= seg_code;
    end
  end

endmodule

`default_nettype wire
